// File: rtl/stack_ctrl_if.sv
// Data-memory port shared by the stack controller (master) and the memory (slave).
// Strobes are held until mem_ack; mem_rdata is valid only while mem_ack is high.
interface stack_ctrl_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
);
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_we;
   logic              mem_re;
   logic              mem_ack;

   modport master (
      output mem_addr, mem_wdata, mem_we, mem_re,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, mem_re,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/stack_ctrl.sv
// Hardware stack sequencer: owns SP, turns push/pop requests into one
// handshaked data-memory access each, rejects overflow/underflow up front.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting; honours sp_load, then push_req, then pop_req
// S_WRITE | mem_we held at sp-1 until mem_ack, then SP decrements
// S_READ  | mem_re held at sp until mem_ack, then SP increments
// S_DONE  | one-cycle done pulse (plus overflow/underflow if rejected)
module stack_ctrl #(
   parameter int                DATA_W      = 16,
   parameter int                ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] STACK_BASE  = 16'hFFFE,
   parameter logic [ADDR_W-1:0] STACK_LIMIT = 16'hFF00
) (
   input  logic              clk,
   input  logic              rst_b,
   input  logic              push_req,
   input  logic              pop_req,
   input  logic [DATA_W-1:0] push_data,
   input  logic              sp_load,
   input  logic [ADDR_W-1:0] sp_load_val,
   output logic              push_done,
   output logic              pop_done,
   output logic [DATA_W-1:0] pop_out,
   output logic              overflow,
   output logic              underflow,
   output logic [ADDR_W-1:0] sp,
   output logic              empty,
   output logic              full,
   output logic              busy,
   stack_ctrl_if.master      mem
);

   localparam logic [ADDR_W-1:0] ONE      = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] SP_EMPTY = STACK_BASE + ONE;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [ADDR_W-1:0] sp_q;
   logic [DATA_W-1:0] pop_out_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              op_push_q;
   logic              op_err_q;

   assign empty         = (sp_q == SP_EMPTY);
   assign full          = (sp_q == STACK_LIMIT);
   assign sp            = sp_q;
   assign pop_out       = pop_out_q;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   // State register; reset abandons any access in flight.
   always_ff @(posedge clk) begin
      if (rst_b) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state: IDLE priority is sp_load > push > pop; rejects skip memory.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (sp_load)       state_d = S_IDLE;
            else if (push_req) state_d = full  ? S_DONE : S_WRITE;
            else if (pop_req)  state_d = empty ? S_DONE : S_READ;
         end
         S_WRITE: if (mem.mem_ack) state_d = S_DONE;
         S_READ:  if (mem.mem_ack) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state; strobes are mutually exclusive by construction.
   always_comb begin
      busy       = 1'b0;
      mem.mem_we = 1'b0;
      mem.mem_re = 1'b0;
      push_done  = 1'b0;
      pop_done   = 1'b0;
      overflow   = 1'b0;
      underflow  = 1'b0;
      case (state_q)
         S_WRITE: begin
            busy       = 1'b1;
            mem.mem_we = 1'b1;
         end
         S_READ: begin
            busy       = 1'b1;
            mem.mem_re = 1'b1;
         end
         S_DONE: begin
            busy      = 1'b1;
            push_done = op_push_q;
            pop_done  = ~op_push_q;
            overflow  = op_push_q & op_err_q;
            underflow = ~op_push_q & op_err_q;
         end
         default: ;
      endcase
   end

   // Datapath: SP, request address/data latch, op flags and popped word.
   always_ff @(posedge clk) begin
      if (rst_b) begin
         sp_q      <= SP_EMPTY;
         pop_out_q <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         op_push_q <= 1'b0;
         op_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (sp_load) begin
                  sp_q <= sp_load_val;
               end else if (push_req) begin
                  op_push_q <= 1'b1;
                  op_err_q  <= full;
                  if (!full) begin
                     addr_q  <= sp_q - ONE;
                     wdata_q <= push_data;
                  end
               end else if (pop_req) begin
                  op_push_q <= 1'b0;
                  op_err_q  <= empty;
                  if (!empty) addr_q <= sp_q;
               end
            end
            S_WRITE: begin
               if (mem.mem_ack) sp_q <= sp_q - ONE;
            end
            S_READ: begin
               if (mem.mem_ack) begin
                  sp_q      <= sp_q + ONE;
                  pop_out_q <= mem.mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Scoreboard bench for stack_ctrl: a reference stack model predicts each
// transaction's outcome at issue time; a monitor compares on every done pulse.
module tb_stack_ctrl;

   localparam logic [15:0] BASE  = 16'hFFFE;
   localparam logic [15:0] LIMIT = 16'hFFFC;
   localparam logic [15:0] EMPTY = 16'hFFFF;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        push_req, pop_req, sp_load;
   logic [15:0] push_data, sp_load_val;
   logic        push_done, pop_done, overflow, underflow;
   logic        empty, full, busy;
   logic [15:0] pop_out, sp;

   stack_ctrl_if #(.DATA_W(16), .ADDR_W(16)) mem_bus ();

   stack_ctrl #(
      .DATA_W(16), .ADDR_W(16), .STACK_BASE(BASE), .STACK_LIMIT(LIMIT)
   ) dut (
      .clk(clk), .rst_b(rst_b),
      .push_req(push_req), .pop_req(pop_req), .push_data(push_data),
      .sp_load(sp_load), .sp_load_val(sp_load_val),
      .push_done(push_done), .pop_done(pop_done), .pop_out(pop_out),
      .overflow(overflow), .underflow(underflow), .sp(sp),
      .empty(empty), .full(full), .busy(busy),
      .mem(mem_bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   // ---------------- memory responder ----------------
   logic [15:0] mem_arr [0:65535];
   int          ack_dly = 0;
   int          wcnt = 0;
   int          acc_count = 0;
   logic [15:0] last_addr = '0;
   logic        last_we = 1'b0;

   // Acks after ack_dly extra strobe cycles; commits writes at the ack.
   always @(negedge clk) begin
      if (mem_bus.mem_we || mem_bus.mem_re) begin
         if (wcnt >= ack_dly) begin
            mem_bus.mem_ack = 1'b1;
            if (mem_bus.mem_we) mem_arr[mem_bus.mem_addr] = mem_bus.mem_wdata;
            else                mem_bus.mem_rdata = mem_arr[mem_bus.mem_addr];
            last_addr = mem_bus.mem_addr;
            last_we   = mem_bus.mem_we;
            acc_count++;
            wcnt = 0;
         end else begin
            mem_bus.mem_ack = 1'b0;
            wcnt++;
         end
      end else begin
         mem_bus.mem_ack   = 1'b0;
         mem_bus.mem_rdata = 16'($urandom);
         wcnt = 0;
      end
   end

   // ---------------- reference model + scoreboard ----------------
   typedef struct {
      bit          is_push;
      bit          err;
      int          t;
      int          lat;
      logic [15:0] addr;
      logic [15:0] data;
      logic [15:0] sp;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] m_sp = EMPTY;
   int          m_acc = 0;

   task automatic issue(input bit is_push, input logic [15:0] d, input int dly, input int t);
      exp_t e;
      e.is_push = is_push;
      e.t       = t;
      e.addr    = '0;
      e.data    = '0;
      if (is_push) begin
         if (m_sp == LIMIT) begin
            e.err = 1'b1;
            e.lat = 1;
         end else begin
            e.err = 1'b0;
            e.lat = dly + 2;
            m_sp  = m_sp - 16'd1;
            ref_mem[m_sp] = d;
            e.addr = m_sp;
            m_acc++;
         end
      end else begin
         if (m_sp == EMPTY) begin
            e.err = 1'b1;
            e.lat = 1;
         end else begin
            e.err  = 1'b0;
            e.lat  = dly + 2;
            e.addr = m_sp;
            e.data = ref_mem[m_sp];
            m_sp   = m_sp + 16'd1;
            m_acc++;
         end
      end
      e.sp  = m_sp;
      e.acc = m_acc;
      sb.push_back(e);
   endtask

   // Monitor: strobe exclusivity every cycle; full comparison on every done/error pulse.
   always @(negedge clk) begin
      exp_t e;
      chk("strobe_excl", {31'd0, mem_bus.mem_we & mem_bus.mem_re}, 32'd0);
      if (push_done || pop_done || overflow || underflow) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {30'd0, push_done, pop_done}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("done_kind", {30'd0, push_done, pop_done}, e.is_push ? 32'd2 : 32'd1);
            chk("overflow", {31'd0, overflow}, {31'd0, e.is_push & e.err});
            chk("underflow", {31'd0, underflow}, {31'd0, ~e.is_push & e.err});
            chk("latency", cyc - e.t, e.lat);
            chk("sp", {16'd0, sp}, {16'd0, e.sp});
            chk("empty", {31'd0, empty}, {31'd0, e.sp == EMPTY});
            chk("full", {31'd0, full}, {31'd0, e.sp == LIMIT});
            chk("busy_done", {31'd0, busy}, 32'd1);
            chk("mem_accesses", acc_count, e.acc);
            if (!e.err) begin
               chk("mem_addr", {16'd0, last_addr}, {16'd0, e.addr});
               chk("mem_dir", {31'd0, last_we}, {31'd0, e.is_push});
               if (!e.is_push) chk("pop_out", {16'd0, pop_out}, {16'd0, e.data});
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_txn(input bit p, input bit q, input logic [15:0] d, input int dly,
                          input bit with_load, input logic [15:0] load_val);
      int t;
      int n;
      bit p_pend;
      bit q_pend;
      @(negedge clk);
      ack_dly   = dly;
      push_data = d;
      push_req  = p;
      pop_req   = q;
      if (with_load) begin
         sp_load     = 1'b1;
         sp_load_val = load_val;
         m_sp        = load_val;
         @(negedge clk);
         sp_load = 1'b0;
         chk("sp_load", {16'd0, sp}, {16'd0, load_val});
      end
      t = cyc;
      if (p)      issue(1'b1, d, dly, t);
      else if (q) issue(1'b0, '0, dly, t);
      p_pend = p;
      q_pend = q;
      n = 0;
      while ((p_pend || q_pend) && n < 200) begin
         @(negedge clk);
         n++;
         if (p_pend && push_done) begin
            push_req = 1'b0;
            p_pend   = 1'b0;
            if (q_pend) issue(1'b0, '0, dly, cyc + 1);
         end else if (!p_pend && q_pend && pop_done) begin
            pop_req = 1'b0;
            q_pend  = 1'b0;
         end
      end
      if (p_pend || q_pend) begin
         checks++;
         errors++;
         $display("FAIL txn_timeout got=no_done exp=done (push %0b pop %0b)", p_pend, q_pend);
         push_req = 1'b0;
         pop_req  = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) begin
         mem_arr[i] = '0;
         ref_mem[i] = '0;
      end
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = '0;
      rst_b = 1'b1;
      push_req = 1'b0; pop_req = 1'b0; sp_load = 1'b0;
      push_data = '0; sp_load_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_sp", {16'd0, sp}, {16'd0, EMPTY});
      chk("rst_pop_out", {16'd0, pop_out}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_strobes", {30'd0, mem_bus.mem_we, mem_bus.mem_re}, 32'd0);
      chk("rst_addr", {16'd0, mem_bus.mem_addr}, 32'd0);
      chk("rst_wdata", {16'd0, mem_bus.mem_wdata}, 32'd0);
      rst_b = 1'b0;

      // Directed: push/pop round trip, underflow, fill to limit, overflow, drain.
      run_txn(1, 0, 16'hBEEF, 0, 0, '0);
      run_txn(0, 1, '0, 3, 0, '0);
      run_txn(0, 1, '0, 1, 0, '0);
      run_txn(1, 0, 16'd1, 0, 0, '0);
      run_txn(1, 0, 16'd2, 2, 0, '0);
      run_txn(1, 0, 16'd3, 1, 0, '0);
      @(negedge clk);
      chk("full_after_3", {31'd0, full}, 32'd1);
      run_txn(1, 0, 16'd4, 0, 0, '0);
      for (int i = 0; i < 3; i++) run_txn(0, 1, '0, i, 0, '0);
      run_txn(1, 0, 16'h1234, 0, 0, '0);
      run_txn(1, 1, 16'hAAAA, 1, 0, '0);
      run_txn(1, 1, 16'h5555, 0, 0, '0);

      // Random mix against the reference model.
      for (int i = 0; i < 150; i++) begin
         int r;
         r = $urandom_range(0, 9);
         run_txn(r < 4 || r >= 8, r >= 4, 16'($urandom), $urandom_range(0, 3), 0, '0);
      end

      // sp_load together with push: load wins, push taken next cycle at FF7F.
      run_txn(1, 0, 16'hC0DE, 1, 1, 16'hFF80);
      run_txn(0, 1, '0, 0, 0, '0);

      // Reset during a WRITE wait: strobe drops, no done, SP back to empty.
      @(negedge clk);
      ack_dly   = 20;
      push_data = 16'h7777;
      push_req  = 1'b1;
      @(negedge clk);
      push_req = 1'b0;
      repeat (2) @(negedge clk);
      chk("write_wait_we", {31'd0, mem_bus.mem_we}, 32'd1);
      rst_b = 1'b1;
      @(negedge clk);
      chk("rst_mid_we", {31'd0, mem_bus.mem_we}, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_sp", {16'd0, sp}, {16'd0, EMPTY});
      rst_b = 1'b0;
      m_sp  = EMPTY;
      repeat (4) @(negedge clk);
      run_txn(0, 1, '0, 0, 0, '0);
      run_txn(1, 0, 16'h0F0F, 2, 0, '0);
      run_txn(0, 1, '0, 0, 0, '0);

      repeat (4) @(negedge clk);
      chk("sb_drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencing controller for the CPU's hardware stack: it accepts push and pop requests from the control unit and runs each one as a single handshaked access on a shared single-port data memory. It owns the stack pointer and returns `push_done` / `pop_done` / `pop_out` to the control unit. It detects overflow and underflow before touching memory. It sits between the control unit and the data-memory port.

## Interface
- `DATA_W`, 16, data word width.
- `ADDR_W`, 16, memory address and SP width.
- `STACK_BASE`, 16'hFFFE, highest stack word address; the empty SP is `STACK_BASE+1`.
- `STACK_LIMIT`, 16'hFF00, lowest legal stack address; SP == `STACK_LIMIT` means full.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_b`  in  1  reset, synchronous, active-high.
- `push_req`  in  1  push request, level; held until `push_done`.
- `pop_req`  in  1  pop request, level; held until `pop_done`.
- `push_data`  in  DATA_W  word to push, sampled in the accept cycle.
- `sp_load`  in  1  load SP from `sp_load_val`; honoured only in IDLE.
- `sp_load_val`  in  ADDR_W  new SP value.
- `push_done`  out  1  one-cycle pulse; push finished or rejected.
- `pop_done`  out  1  one-cycle pulse; pop finished or rejected.
- `pop_out`  out  DATA_W  popped word, registered, valid from the `pop_done` cycle until the next pop.
- `overflow`  out  1  one-cycle pulse with `push_done` when a push is rejected.
- `underflow`  out  1  one-cycle pulse with `pop_done` when a pop is rejected.
- `sp`  out  ADDR_W  current stack pointer (points at the last pushed word).
- `empty`, `full`  out  1 each  combinational: `sp == STACK_BASE+1` and `sp == STACK_LIMIT` respectively.
- `busy`  out  1  high in every state other than IDLE.
- `mem_addr`  out  ADDR_W, `mem_wdata`  out  DATA_W  memory request address and write data.
- `mem_we`, `mem_re`  out  1 each  write and read strobes; held high until ack.
- `mem_rdata`  in  DATA_W  read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  memory completion; may arrive in the first strobe cycle or any cycle after.

## Operation
- Stack is full-descending. Push writes `sp-1` and then decrements SP. Pop reads `sp` and then increments SP.
- States: IDLE, WRITE, READ, DONE.
- **IDLE**, evaluated in priority order:
  - `sp_load`: SP <= `sp_load_val`; no access; stay in IDLE.
  - `push_req` (wins over a simultaneous `pop_req`):
    - If `full`: go to DONE with the overflow flag set. No memory strobe; SP unchanged.
    - Otherwise: latch `push_data`, set `mem_addr` = `sp-1`, go to WRITE.
  - `pop_req`:
    - If `empty`: go to DONE with the underflow flag set. No memory strobe; SP unchanged.
    - Otherwise: set `mem_addr` = `sp`, go to READ.
- **WRITE**: `mem_we`=1, `mem_wdata` = latched data. On `mem_ack`: SP <= SP-1, go to DONE.
- **READ**: `mem_re`=1. On `mem_ack`: `pop_out` <= `mem_rdata`, SP <= SP+1, go to DONE.
- **DONE**: pulse the matching done signal, plus `overflow` or `underflow` if flagged. Always return to IDLE.
- A pop losing a simultaneous push stays pending; it is accepted on the first IDLE cycle after the push's DONE.
- `sp_load`, `push_req` and `pop_req` are ignored while busy.
- SP arithmetic is modulo 2^ADDR_W. Bounds are enforced only by the full/empty checks; an `sp_load` outside [LIMIT, BASE+1] is accepted as given.
- `mem_we` and `mem_re` are never high together. Both are low in IDLE and DONE.

## Timing
- Reset (`rst_b`=1 at an edge): state IDLE; `sp` = `STACK_BASE+1`; `pop_out` = 0. All pulses, strobes, `mem_addr`, `mem_wdata` and `busy` = 0.
- Reset mid-transaction abandons the access. Strobes drop at that edge; no done pulse is issued.
- Request accepted in IDLE cycle T. Strobe is high from T+1 through the cycle in which `mem_ack`=1 (cycle A). DONE is at A+1; SP, `pop_out` and the done pulse are all visible at A+1.
- Minimum latency (ack in the first strobe cycle): request at T, done at T+2.
- Rejected push or pop: done and error pulse at T+1; `busy`=1 only in that cycle.
- The requester must drop its request by the edge ending the DONE cycle. A request still high in the next IDLE is taken as a new request.

## Test plan
- Reset, then push 16'hBEEF with 0-cycle ack → `mem_addr`=16'hFFFE, `mem_we` high for 1 cycle, `push_done` 2 cycles after the request, `sp`=16'hFFFE, `empty`=0.
- Pop after that push, with ack delayed 3 cycles → `mem_re` high for 4 cycles at 16'hFFFE; `pop_out`=16'hBEEF with `pop_done`; `sp`=16'hFFFF; `empty`=1.
- Pop from empty → `pop_done` and `underflow` 1 cycle after the request; no `mem_re`; `sp` stays 16'hFFFF.
- STACK_LIMIT=16'hFFFC: three pushes (1, 2, 3) fill the stack (`full`=1, `sp`=16'hFFFC). A fourth push gives `push_done` and `overflow` with no `mem_we`. Then three pops return 3, 2, 1.
- `push_req` and `pop_req` raised together on a non-empty stack → push completes first, then the pop returns the just-pushed word; net SP unchanged.
- `sp_load` of 16'hFF80 together with `push_req` in IDLE → SP loads to 16'hFF80, push accepted the next cycle at address 16'hFF7F. Separately: `rst_b` asserted during a WRITE wait → strobes low at the next edge, no done pulse, `sp`=16'hFFFF.
